// File: rtl/ahb_bridge_pkg.sv
// Shared AHB encodings, captured-control layout and FSM states for the
// registered AHB bridge.
package ahb_bridge_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_M_ADDR,
    ST_M_DATA,
    ST_S_RESP,
    ST_ERR1,
    ST_ERR2,
    ST_DRAIN
  } state_t;

  typedef struct packed {
    logic [2:0] hsize;
    logic [6:0] hprot;
    logic       hwrite;
    logic       hmastlock;
    logic       hnonsec;
    logic       hexcl;
    logic [3:0] hmaster;
  } ctrl_t;

  // A disabled timeout (limit 0) still needs a 1-bit counter to stay legal.
  function automatic int cnt_width(input int limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/ahb_timeout_cnt.sv
// Counts stalled downstream data-phase cycles and flags the cycle that
// reaches LIMIT; LIMIT of 0 never expires.
module ahb_timeout_cnt #(
  parameter int LIMIT = 0,
  parameter int W     = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam bit         ENABLED = (LIMIT > 0);
  localparam logic [W-1:0] LAST  = ENABLED ? W'(LIMIT - 1) : '0;

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_expire = ENABLED && i_enable && (r_count == LAST);

endmodule

// File: rtl/ahb_sync_bridge.sv
// Registered AHB bridge: each accepted beat is re-issued downstream as a
// SINGLE NONSEQ transfer, with optional downstream stall timeout.
module ahb_sync_bridge
  import ahb_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,

  input  logic                  slave_hsel,
  input  logic [ADDR_WIDTH-1:0] slave_haddr,
  input  logic [2:0]            slave_hburst,
  input  logic                  slave_hmastlock,
  input  logic [6:0]            slave_hprot,
  input  logic [2:0]            slave_hsize,
  input  logic                  slave_hnonsec,
  input  logic                  slave_hexcl,
  input  logic [3:0]            slave_hmaster,
  input  logic [1:0]            slave_htrans,
  input  logic [DATA_WIDTH-1:0] slave_hwdata,
  input  logic                  slave_hwrite,
  input  logic                  slave_hready_in,
  output logic [DATA_WIDTH-1:0] slave_hrdata,
  output logic                  slave_hready,
  output logic                  slave_hresp,
  output logic                  slave_hexokay,

  output logic                  master_hsel,
  output logic [ADDR_WIDTH-1:0] master_haddr,
  output logic [2:0]            master_hburst,
  output logic                  master_hmastlock,
  output logic [6:0]            master_hprot,
  output logic [2:0]            master_hsize,
  output logic                  master_hnonsec,
  output logic                  master_hexcl,
  output logic [3:0]            master_hmaster,
  output logic [1:0]            master_htrans,
  output logic [DATA_WIDTH-1:0] master_hwdata,
  output logic                  master_hwrite,
  output logic                  master_hready_in,
  input  logic [DATA_WIDTH-1:0] master_hrdata,
  input  logic                  master_hready,
  input  logic                  master_hresp,
  input  logic                  master_hexokay
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  ctrl_t                 r_ctrl;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_exokay;
  logic                  r_timed_out;
  logic                  r_pend;

  logic w_slave_hready;
  logic w_accept;
  logic w_expire;
  logic w_unused;

  // Burst type and SEQ/NONSEQ distinction are dropped: every beat goes out SINGLE.
  assign w_unused = ^{slave_hburst, slave_htrans[0]};

  assign w_accept = slave_hsel & slave_hready_in & w_slave_hready & slave_htrans[1];

  ahb_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (CNT_W)
  ) u_timeout_cnt (
    .i_clk    (hclk),
    .i_rst_n  (hresetn),
    .i_clear  (r_state != ST_M_DATA),
    .i_enable ((r_state == ST_M_DATA) && !master_hready),
    .o_expire (w_expire)
  );

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_addr <= '0;
      r_ctrl <= '0;
    end else if (w_accept) begin
      r_addr <= slave_haddr;
      r_ctrl <= '{hsize: slave_hsize, hprot: slave_hprot, hwrite: slave_hwrite,
                  hmastlock: slave_hmastlock, hnonsec: slave_hnonsec,
                  hexcl: slave_hexcl, hmaster: slave_hmaster};
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state     <= ST_IDLE;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_exokay    <= 1'b0;
      r_timed_out <= 1'b0;
      r_pend      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_S_RESP: begin
          r_state <= w_accept ? ST_M_ADDR : ST_IDLE;
        end
        ST_M_ADDR: begin
          r_wdata <= slave_hwdata;
          if (master_hready) r_state <= ST_M_DATA;
        end
        ST_M_DATA: begin
          if (master_hready) begin
            if (master_hresp) begin
              r_state <= ST_ERR1;
            end else begin
              r_rdata  <= master_hrdata;
              r_exokay <= master_hexokay;
              r_state  <= ST_S_RESP;
            end
          end else if (w_expire) begin
            r_timed_out <= 1'b1;
            r_state     <= ST_ERR1;
          end
        end
        ST_ERR1: begin
          r_state <= ST_ERR2;
        end
        ST_ERR2: begin
          // The abandoned downstream transfer may still be stalled; park it in DRAIN.
          if (r_timed_out) begin
            r_state <= ST_DRAIN;
            if (w_accept) r_pend <= 1'b1;
          end else begin
            r_state <= w_accept ? ST_M_ADDR : ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (w_accept) r_pend <= 1'b1;
          if (master_hready) begin
            r_timed_out <= 1'b0;
            r_pend      <= 1'b0;
            r_state     <= (r_pend || w_accept) ? ST_M_ADDR : ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_slave_hready = 1'b1;
    case (r_state)
      ST_M_ADDR, ST_M_DATA, ST_ERR1: w_slave_hready = 1'b0;
      ST_DRAIN:                      w_slave_hready = ~r_pend;
      default:                       w_slave_hready = 1'b1;
    endcase
  end

  assign slave_hready  = w_slave_hready;
  assign slave_hresp   = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign slave_hrdata  = r_rdata;
  assign slave_hexokay = r_exokay;

  assign master_hsel      = (r_state == ST_M_ADDR);
  assign master_htrans    = (r_state == ST_M_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign master_hburst    = HBURST_SINGLE;
  assign master_haddr     = r_addr;
  assign master_hsize     = r_ctrl.hsize;
  assign master_hprot     = r_ctrl.hprot;
  assign master_hwrite    = r_ctrl.hwrite;
  assign master_hmastlock = r_ctrl.hmastlock;
  assign master_hnonsec   = r_ctrl.hnonsec;
  assign master_hexcl     = r_ctrl.hexcl;
  assign master_hmaster   = r_ctrl.hmaster;
  assign master_hwdata    = r_wdata;
  assign master_hready_in = master_hready;

endmodule

// File: tb/tb_ahb_sync_bridge.sv
// Directed bench for ahb_sync_bridge: single write/read, wait states,
// downstream error, stall timeout with drain, burst flattening and reset.
module tb_ahb_sync_bridge;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;

  logic        slave_hsel = 1'b0;
  logic [31:0] slave_haddr = '0;
  logic [2:0]  slave_hburst = '0;
  logic        slave_hmastlock = 1'b0;
  logic [6:0]  slave_hprot = '0;
  logic [2:0]  slave_hsize = 3'b010;
  logic        slave_hnonsec = 1'b0;
  logic        slave_hexcl = 1'b0;
  logic [3:0]  slave_hmaster = '0;
  logic [1:0]  slave_htrans = '0;
  logic [31:0] slave_hwdata = '0;
  logic        slave_hwrite = 1'b0;
  logic        slave_hready_in = 1'b1;
  logic [31:0] slave_hrdata;
  logic        slave_hready;
  logic        slave_hresp;
  logic        slave_hexokay;

  logic        master_hsel;
  logic [31:0] master_haddr;
  logic [2:0]  master_hburst;
  logic        master_hmastlock;
  logic [6:0]  master_hprot;
  logic [2:0]  master_hsize;
  logic        master_hnonsec;
  logic        master_hexcl;
  logic [3:0]  master_hmaster;
  logic [1:0]  master_htrans;
  logic [31:0] master_hwdata;
  logic        master_hwrite;
  logic        master_hready_in;
  logic [31:0] master_hrdata = '0;
  logic        master_hready = 1'b1;
  logic        master_hresp = 1'b0;
  logic        master_hexokay = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;
  int low_run = 0;
  int last_low_run = 0;

  always #5 hclk = ~hclk;

  ahb_sync_bridge #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .hclk             (hclk),
    .hresetn          (hresetn),
    .slave_hsel       (slave_hsel),
    .slave_haddr      (slave_haddr),
    .slave_hburst     (slave_hburst),
    .slave_hmastlock  (slave_hmastlock),
    .slave_hprot      (slave_hprot),
    .slave_hsize      (slave_hsize),
    .slave_hnonsec    (slave_hnonsec),
    .slave_hexcl      (slave_hexcl),
    .slave_hmaster    (slave_hmaster),
    .slave_htrans     (slave_htrans),
    .slave_hwdata     (slave_hwdata),
    .slave_hwrite     (slave_hwrite),
    .slave_hready_in  (slave_hready_in),
    .slave_hrdata     (slave_hrdata),
    .slave_hready     (slave_hready),
    .slave_hresp      (slave_hresp),
    .slave_hexokay    (slave_hexokay),
    .master_hsel      (master_hsel),
    .master_haddr     (master_haddr),
    .master_hburst    (master_hburst),
    .master_hmastlock (master_hmastlock),
    .master_hprot     (master_hprot),
    .master_hsize     (master_hsize),
    .master_hnonsec   (master_hnonsec),
    .master_hexcl     (master_hexcl),
    .master_hmaster   (master_hmaster),
    .master_htrans    (master_htrans),
    .master_hwdata    (master_hwdata),
    .master_hwrite    (master_hwrite),
    .master_hready_in (master_hready_in),
    .master_hrdata    (master_hrdata),
    .master_hready    (master_hready),
    .master_hresp     (master_hresp),
    .master_hexokay   (master_hexokay)
  );

  // Length of the most recent run of slave wait states.
  always @(negedge hclk) begin
    if (!hresetn) begin
      low_run = 0;
    end else if (!slave_hready) begin
      low_run = low_run + 1;
    end else begin
      if (low_run != 0) last_low_run = low_run;
      low_run = 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic sample();
    @(negedge hclk);
  endtask

  task automatic drive_addr(input logic [31:0] addr, input logic wr, input logic [1:0] tr,
                            input logic [2:0] burst);
    slave_hsel   = 1'b1;
    slave_haddr  = addr;
    slave_hwrite = wr;
    slave_htrans = tr;
    slave_hburst = burst;
  endtask

  task automatic drive_idle();
    slave_hsel   = 1'b0;
    slave_htrans = 2'b00;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_hready"}, slave_hready, 1'b1);
    check({tag, "_s_hresp"}, slave_hresp, 1'b0);
    check({tag, "_s_hrdata"}, slave_hrdata, 32'h0);
    check({tag, "_s_hexokay"}, slave_hexokay, 1'b0);
    check({tag, "_m_htrans"}, master_htrans, 2'b00);
    check({tag, "_m_hsel"}, master_hsel, 1'b0);
    check({tag, "_m_haddr"}, master_haddr, 32'h0);
    check({tag, "_m_hwrite"}, master_hwrite, 1'b0);
    check({tag, "_m_hwdata"}, master_hwdata, 32'h0);
    check({tag, "_m_hburst"}, master_hburst, 3'b000);
  endtask

  initial begin
    // Reset state
    sample();
    check_reset_outputs("rst");
    tick();
    tick();
    hresetn = 1'b1;

    // Zero-wait write 0x1000 / 0xDEADBEEF
    tick();
    drive_addr(32'h1000, 1'b1, 2'b10, 3'b000);
    tick();
    drive_idle();
    slave_hwdata = 32'hDEADBEEF;
    sample();
    check("wr_m_htrans", master_htrans, 2'b10);
    check("wr_m_haddr", master_haddr, 32'h1000);
    check("wr_m_hsel", master_hsel, 1'b1);
    check("wr_m_hwrite", master_hwrite, 1'b1);
    check("wr_m_hsize", master_hsize, 3'b010);
    check("wr_s_hready_a", slave_hready, 1'b0);
    tick();
    sample();
    check("wr_m_htrans_d", master_htrans, 2'b00);
    check("wr_m_hwdata", master_hwdata, 32'hDEADBEEF);
    check("wr_s_hready_d", slave_hready, 1'b0);
    tick();
    sample();
    check("wr_s_hready_r", slave_hready, 1'b1);
    check("wr_s_hresp", slave_hresp, 1'b0);
    tick();
    check("wr_wait_states", last_low_run, 2);

    // Read 0x2000 with three downstream wait states
    drive_addr(32'h2000, 1'b0, 2'b10, 3'b000);
    tick();
    drive_idle();
    sample();
    check("rd_m_haddr", master_haddr, 32'h2000);
    check("rd_m_hwrite", master_hwrite, 1'b0);
    tick();
    master_hready = 1'b0;
    tick();
    tick();
    tick();
    master_hready  = 1'b1;
    master_hrdata  = 32'h12345678;
    master_hexokay = 1'b1;
    sample();
    check("rd_s_hready_wait", slave_hready, 1'b0);
    tick();
    master_hrdata  = 32'h0;
    master_hexokay = 1'b0;
    sample();
    check("rd_s_hrdata", slave_hrdata, 32'h12345678);
    check("rd_s_hresp", slave_hresp, 1'b0);
    check("rd_s_hready", slave_hready, 1'b1);
    check("rd_s_hexokay", slave_hexokay, 1'b1);
    tick();
    check("rd_wait_states", last_low_run, 5);

    // Stall timeout, read accepted during ERR2 is held until downstream frees
    drive_addr(32'h2008, 1'b0, 2'b10, 3'b000);
    tick();
    drive_idle();
    tick();
    master_hready = 1'b0;
    sample();
    check("to_s_hresp_0", slave_hresp, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      sample();
      check("to_s_hresp_wait", slave_hresp, 1'b0);
    end
    tick();
    sample();
    check("to_err1_hresp", slave_hresp, 1'b1);
    check("to_err1_hready", slave_hready, 1'b0);
    tick();
    drive_addr(32'h4000, 1'b0, 2'b10, 3'b000);
    sample();
    check("to_err2_hresp", slave_hresp, 1'b1);
    check("to_err2_hready", slave_hready, 1'b1);
    tick();
    drive_idle();
    sample();
    check("to_drain_hready", slave_hready, 1'b0);
    check("to_drain_hresp", slave_hresp, 1'b0);
    check("to_drain_htrans", master_htrans, 2'b00);
    for (int k = 7; k <= 10; k++) begin
      tick();
      if (k == 10) master_hready = 1'b1;
      sample();
      check("to_drain_hold", master_htrans, 2'b00);
    end
    tick();
    sample();
    check("to_pend_htrans", master_htrans, 2'b10);
    check("to_pend_haddr", master_haddr, 32'h4000);
    tick();
    master_hrdata = 32'hCAFEF00D;
    tick();
    master_hrdata = 32'h0;
    sample();
    check("to_pend_hrdata", slave_hrdata, 32'hCAFEF00D);
    check("to_pend_hresp", slave_hresp, 1'b0);

    // Downstream ERROR on read; follow-up accepted in ERR2 goes straight out
    tick();
    drive_addr(32'h2004, 1'b0, 2'b10, 3'b000);
    tick();
    drive_idle();
    tick();
    master_hready = 1'b0;
    master_hresp  = 1'b1;
    tick();
    master_hready = 1'b1;
    tick();
    master_hresp = 1'b0;
    sample();
    check("err1_hresp", slave_hresp, 1'b1);
    check("err1_hready", slave_hready, 1'b0);
    tick();
    drive_addr(32'h2010, 1'b0, 2'b10, 3'b000);
    sample();
    check("err2_hresp", slave_hresp, 1'b1);
    check("err2_hready", slave_hready, 1'b1);
    tick();
    drive_idle();
    sample();
    check("err_next_htrans", master_htrans, 2'b10);
    check("err_next_haddr", master_haddr, 32'h2010);
    check("err_next_hresp", slave_hresp, 1'b0);
    tick();
    master_hrdata = 32'h0BADF00D;
    tick();
    master_hrdata = 32'h0;
    sample();
    check("err_next_hrdata", slave_hrdata, 32'h0BADF00D);

    // INCR4 write burst flattened to four SINGLE NONSEQ beats
    master_hrdata  = 32'h55AA55AA;
    master_hexokay = 1'b1;
    tick();
    drive_addr(32'h3000, 1'b1, 2'b10, 3'b011);
    for (int b = 0; b < 4; b++) begin
      tick();
      slave_hwdata = 32'hB000_0000 + b;
      if (b < 3) drive_addr(32'h3000 + 4 * (b + 1), 1'b1, 2'b11, 3'b011);
      else drive_idle();
      sample();
      check("burst_m_htrans", master_htrans, 2'b10);
      check("burst_m_hburst", master_hburst, 3'b000);
      check("burst_m_haddr", master_haddr, 32'h3000 + 4 * b);
      tick();
      sample();
      check("burst_m_hwdata", master_hwdata, 32'hB000_0000 + b);
      tick();
      sample();
      check("burst_s_hready", slave_hready, 1'b1);
    end

    // Reset pulse in the middle of a second burst
    tick();
    drive_addr(32'h3100, 1'b1, 2'b10, 3'b011);
    tick();
    drive_addr(32'h3104, 1'b1, 2'b11, 3'b011);
    slave_hwdata = 32'hC0C0C0C0;
    tick();
    hresetn = 1'b0;
    sample();
    check_reset_outputs("midrst");
    tick();
    sample();
    check_reset_outputs("midrst_hold");
    tick();
    hresetn = 1'b1;
    drive_idle();
    sample();
    check("post_rst_htrans", master_htrans, 2'b00);
    check("post_rst_hready", slave_hready, 1'b1);
    tick();
    sample();
    check("post_rst_hsel", master_hsel, 1'b0);
    check("post_rst_hresp", slave_hresp, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ahb_sync_bridge.md
AHB_SYNC_BRIDGE -- requirements
Module: ahb_sync_bridge

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 32, address width; DATA_WIDTH, 32, data width; TIMEOUT_CYCLES, 0, downstream wait limit (0 = disabled).
REQ-002 Ports SHALL be: hclk  in  1  clock; hresetn  in  1  reset (one clock; reset is asynchronous and active-low).
REQ-003 Subordinate-side inputs SHALL be slave_hsel, slave_haddr[ADDR_WIDTH], slave_hburst[3], slave_hmastlock, slave_hprot[7], slave_hsize[3], slave_hnonsec, slave_hexcl, slave_hmaster[4], slave_htrans[2], slave_hwdata[DATA_WIDTH], slave_hwrite, slave_hready_in.
REQ-004 Subordinate-side outputs SHALL be slave_hrdata[DATA_WIDTH], slave_hready, slave_hresp, slave_hexokay.
REQ-005 Manager-side outputs SHALL mirror REQ-003 names with prefix master_ (including master_hsel, master_hready_in); manager-side inputs SHALL be master_hrdata[DATA_WIDTH], master_hready, master_hresp, master_hexokay.

Function
REQ-006 Block SHALL be a registered AHB bridge; no combinational path from slave_* inputs to master_* outputs or vice versa.
REQ-007 Accept condition SHALL be slave_hsel & slave_hready_in & slave_hready & slave_htrans[1]; address/control SHALL be captured on that edge.
REQ-008 FSM states SHALL be IDLE, M_ADDR, M_DATA, S_RESP, ERR1, ERR2, DRAIN.
REQ-009 IDLE: slave_hready=1, slave_hresp=0; accept -> M_ADDR; IDLE/BUSY or unselected transfers get zero-wait OKAY.
REQ-010 M_ADDR: master_htrans=NONSEQ, master_hburst=SINGLE, master_hsel=1, other controls from capture register; slave_hwdata captured this cycle; slave_hready=0; master_hready=1 -> M_DATA.
REQ-011 M_DATA: master_htrans=IDLE, master_hwdata from capture register, slave_hready=0; master_hready=1 & master_hresp=0 -> capture hrdata/hexokay, S_RESP; master_hready=1 & master_hresp=1 -> ERR1.
REQ-012 S_RESP: slave_hready=1, slave_hrdata/slave_hexokay from capture, slave_hresp=0; accept -> M_ADDR else IDLE.
REQ-013 ERR1: slave_hready=0, slave_hresp=1; ERR2: slave_hready=1, slave_hresp=1; ERR2 accept -> M_ADDR, else IDLE, unless timeout flagged (REQ-015).
REQ-014 Timeout counter SHALL count M_DATA cycles with master_hready=0; reaching TIMEOUT_CYCLES (nonzero) SHALL set timed_out and enter ERR1.
REQ-015 After timeout ERR2 SHALL go to DRAIN; a transfer accepted in ERR2 or DRAIN sets pend; DRAIN drives slave_hready=~pend, holds master controls IDLE; master_hready=1 -> M_ADDR if pend else IDLE, clearing timed_out.
REQ-016 Minimum slave data-phase latency SHALL be 3 cycles (2 wait states) with zero-wait downstream.
REQ-017 master_hready_in SHALL equal master_hready.
REQ-018 Burst transfers SHALL be flattened to SINGLE NONSEQ per beat; slave_hburst SHALL be ignored.

Reset
REQ-019 On hresetn low: state=IDLE, counter=0, timed_out=0, pend=0, capture registers 0.
REQ-020 Reset outputs: slave_hready=1, slave_hresp=0, slave_hrdata=0, slave_hexokay=0, master_htrans=IDLE, master_hsel=0, all other master_* outputs 0.
REQ-021 Reset mid-transfer SHALL abandon it with no completion reported on either side.

Structure
REQ-022 Package ahb_bridge_pkg SHALL hold HTRANS/HBURST encodings, HRESP values and the FSM state enum.
REQ-023 Timeout counter SHALL be sub-module ahb_timeout_cnt (width $clog2(TIMEOUT_CYCLES+1), clear/enable/expire).

Verification
REQ-024 Write 0x1000 data 0xDEADBEEF, zero-wait downstream -> master NONSEQ at 0x1000 one cycle after accept, master_hwdata=0xDEADBEEF, slave_hready low 2 cycles.
REQ-025 Read 0x2000, downstream 3 wait states, hrdata=0x12345678 -> slave_hrdata=0x12345678, slave_hresp=0, slave_hready low 5 cycles.
REQ-026 Downstream ERROR on read -> slave sees hresp=1/hready=0 then hresp=1/hready=1.
REQ-027 TIMEOUT_CYCLES=4, master_hready held low 10 cycles -> slave two-cycle ERROR after 4 cycles; read accepted in ERR2 issued only after master_hready rises.
REQ-028 INCR4 write burst 0x3000 -> four SINGLE NONSEQ at 0x3000/4/8/C; hresetn pulse mid-burst -> all outputs at REQ-020 values next cycle.
